// File: rtl/kt_pkg.sv
// Shared constants and state encodings for the KnightsTour remote-command UART link.
// Response codes and the default bit period live here so both ends agree on them.
package kt_pkg;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // 50 MHz system clock, 19200 baud
    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {PAIR_HIGH, PAIR_LOW} pair_state_t;

endpackage

// File: rtl/uart_byte_trx.sv
// Raw 8N1 byte engine: synchronised receiver sampling at bit centres and an
// independent transmitter. Receive/transmit events are single-cycle strobes.
module uart_byte_trx
    import kt_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_err,
    output logic       rx_start,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

    logic            rx_ff1, rx_ff2, rx_prev;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_baud;
    logic [3:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_fall, rx_tick;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_baud;
    logic [3:0]      tx_bit;
    logic [8:0]      tx_shift;
    logic            tx_tick;

    // Preset to 1 so a line idling high never looks like a start edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= rx;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    assign rx_fall  = rx_prev & ~rx_ff2;
    assign rx_tick  = (rx_state == RX_RECV) && (rx_baud == CW'(1));
    assign rx_start = (rx_state == RX_IDLE) && rx_fall;
    assign rx_rdy   = rx_tick && (rx_bit == 4'd9) && rx_ff2;
    assign rx_err   = rx_tick && (rx_bit == 4'd9) && !rx_ff2;
    assign rx_data  = rx_shift;

    // rx_bit: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_baud  <= HALF;
                        rx_bit   <= '0;
                        rx_state <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (rx_tick) begin
                        rx_baud <= FULL;
                        if ((rx_bit == 4'd0) && rx_ff2) begin
                            rx_state <= RX_IDLE;
                        end else if (rx_bit == 4'd9) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            if (rx_bit != 4'd0)
                                rx_shift <= {rx_ff2, rx_shift[7:1]};
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end else begin
                        rx_baud <= rx_baud - CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign tx_tick = (tx_state == TX_XMIT) && (tx_baud == CW'(1));
    assign tx_done = tx_tick && (tx_bit == 4'd9);
    assign tx_busy = (tx_state == TX_XMIT);

    // The start bit is driven directly; tx_shift holds the data bits plus stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift <= {1'b1, tx_data};
                        tx       <= 1'b0;
                        tx_baud  <= FULL;
                        tx_bit   <= '0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_tick) begin
                        tx_baud <= FULL;
                        if (tx_bit == 4'd9) begin
                            tx       <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_baud <= tx_baud - CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Remote-command endpoint: pairs received bytes (high first) into 16-bit commands
// and returns single-byte responses over the same UART link.
module uart_cmd_wrapper
    import kt_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    logic [7:0]  rx_data;
    logic        rx_rdy, rx_err, rx_start;
    logic        tx_busy, tx_done;
    pair_state_t pair_state;
    logic [7:0]  cmd_hi;

    uart_byte_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .tx       (TX),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .rx_err   (rx_err),
        .rx_start (rx_start),
        .trmt     (send_resp),
        .tx_data  (resp),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // A framing error drops any half-built command so the next good byte starts a new pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_state <= PAIR_HIGH;
            cmd_hi     <= '0;
            cmd        <= '0;
        end else if (rx_err) begin
            pair_state <= PAIR_HIGH;
        end else if (rx_rdy) begin
            case (pair_state)
                PAIR_HIGH: begin
                    cmd_hi     <= rx_data;
                    pair_state <= PAIR_LOW;
                end
                PAIR_LOW: begin
                    cmd        <= {cmd_hi, rx_data};
                    pair_state <= PAIR_HIGH;
                end
                default: pair_state <= PAIR_HIGH;
            endcase
        end
    end

    // A completing pair outranks a same-cycle acknowledge so no command is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmd_rdy <= 1'b0;
        else if (rx_rdy && (pair_state == PAIR_LOW))
            cmd_rdy <= 1'b1;
        else if (clr_cmd_rdy || (rx_start && (pair_state == PAIR_HIGH)))
            cmd_rdy <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resp_sent <= 1'b0;
        else if (tx_done)
            resp_sent <= 1'b1;
        else if (send_resp && !tx_busy)
            resp_sent <= 1'b0;
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: a far-end serial model drives RX and decodes TX,
// while a byte-pairing model predicts the commands the endpoint must present.
module tb_uart_cmd_wrapper;
    import kt_pkg::*;

    localparam int BD = 16;

    logic        clk;
    logic        rst_n;
    logic        rx_line;
    logic        tx_line;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx_line),
        .TX          (tx_line),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q[$];
    bit          have_hi = 1'b0;
    logic [7:0]  hi_byte = 8'h00;
    logic [15:0] last_cmd = 16'h0000;
    logic        rdy_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every new command presentation must match the next pair the model formed.
    always @(negedge clk) begin
        if (rst_n && cmd_rdy && !rdy_prev) begin
            check_eq("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                last_cmd = exp_q.pop_front();
                check_eq("cmd", cmd, last_cmd);
            end
        end
        rdy_prev = cmd_rdy;
    end

    // ---------------- driver tasks ----------------
    task automatic ser_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            if (have_hi) begin
                exp_q.push_back({hi_byte, b});
                have_hi = 1'b0;
            end else begin
                hi_byte = b;
                have_hi = 1'b1;
            end
        end else begin
            have_hi = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_line = fr[i];
            repeat (BD) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2);
        ser_byte(b1, 1'b1);
        check_eq("rdy_low_after_byte1", cmd_rdy, 1'b0);
        ser_byte(b2, 1'b1);
        check_eq("rdy_set_after_byte2", cmd_rdy, 1'b1);
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check_eq("rdy_cleared", cmd_rdy, 1'b0);
        check_eq("cmd_hold", cmd, last_cmd);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_tx", tx_line, 1'b1);
        check_eq("rst_cmd_rdy", cmd_rdy, 1'b0);
        check_eq("rst_resp_sent", resp_sent, 1'b0);
        check_eq("rst_cmd", cmd, 16'h0000);
    endtask

    // Decode one response frame bit by bit; optionally fire a stray strobe at cycle inject_at.
    task automatic tx_frame(input logic [7:0] r, input int inject_at);
        logic [9:0] fr;
        fr = {1'b1, r, 1'b0};
        @(negedge clk);
        resp      = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int n = 0; n < 10 * BD; n++) begin
            check_eq("tx_bit", tx_line, fr[n / BD]);
            if (n == 0 || n == 10 * BD - 1)
                check_eq("resp_sent_low", resp_sent, 1'b0);
            if (n == inject_at) begin
                resp      = ~r;
                send_resp = 1'b1;
            end else begin
                send_resp = 1'b0;
            end
            @(negedge clk);
        end
        send_resp = 1'b0;
        resp      = r;
        check_eq("tx_end_idle", tx_line, 1'b1);
        check_eq("resp_sent_high", resp_sent, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_eq("tx_stays_idle", tx_line, 1'b1);
        end
        check_eq("resp_sent_hold", resp_sent, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        rx_line     = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        rst_n       = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_pair(8'h4F, 8'h23);
        clear_rdy();

        tx_frame(RESP_DONE, -1);
        tx_frame(RESP_BUSY, -1);

        // Bad stop on 0x12 must not leave it waiting as a high byte.
        ser_byte(8'h12, 1'b0);
        send_pair(8'hAB, 8'hCD);
        clear_rdy();

        @(negedge clk);
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_no_cmd", cmd_rdy, 1'b0);
        send_pair(8'h11, 8'h22);
        clear_rdy();
        tx_frame(8'h3C, 50);
        tx_frame(8'hC3, 10 * BD - 1);

        ser_byte(8'h77, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        have_hi  = 1'b0;
        last_cmd = 16'h0000;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        send_pair(8'h01, 8'h02);
        clear_rdy();

        // Hold the acknowledge high across the cycle a pair completes.
        ser_byte(8'h03, 1'b1);
        check_eq("rdy_low_before_set", cmd_rdy, 1'b0);
        clr_cmd_rdy = 1'b1;
        seen = 1'b0;
        fork
            ser_byte(8'h04, 1'b1);
            begin
                for (int i = 0; i < 12 * BD && !seen; i++) begin
                    @(negedge clk);
                    if (cmd_rdy) begin
                        seen = 1'b1;
                        clr_cmd_rdy = 1'b0;
                    end
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check_eq("set_wins", seen, 1'b1);
        check_eq("set_wins_hold", cmd_rdy, 1'b1);
        clear_rdy();

        for (int it = 0; it < 14; it++) begin
            int kind;
            int inj;
            logic [7:0] b1, b2, r;
            kind = $urandom_range(0, 9);
            b1   = 8'($urandom);
            b2   = 8'($urandom);
            r    = 8'($urandom);
            inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150)) : -1;
            if (kind == 0) begin
                ser_byte(b1, 1'b0);
            end else if (kind < 4) begin
                fork
                    send_pair(b1, b2);
                    tx_frame(r, inj);
                join
            end else begin
                send_pair(b1, b2);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                clear_rdy();
        end

        repeat (10) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
